clint_timer: RTL and testbench

- Core-local interruptor for the RISC-V core.
- Holds the 64-bit machine timer `mtime`, the compare register `mtimecmp` and the software-interrupt bit `msip`.
- Drives the core's `mtip` and `msip` interrupt inputs.
- Reached through a simple 32-bit valid/ready register bus from the SoC interconnect. Replaces the testbench-driven interrupt stimulus in integrated builds.

---
 rtl/clint_pkg.sv | 18 +
 rtl/clint_prescaler.sv | 27 ++
 rtl/clint_timer.sv | 163 ++++++++++++++++
 tb/tb_clint_timer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared register map, bus FSM states and reset constants for the CLINT.
package clint_pkg;

    localparam int MSIP_OFF        = 'h00;
    localparam int MTIMECMP_LO_OFF = 'h08;
    localparam int MTIMECMP_HI_OFF = 'h0C;
    localparam int MTIME_LO_OFF    = 'h10;
    localparam int MTIME_HI_OFF    = 'h14;
    localparam int PRESC_OFF       = 'h18;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } bus_state_e;

endpackage

// File: rtl/clint_prescaler.sv
// Tick generator for mtime: one tick every presc+1 clocks.
module clint_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] count;

    assign tick = (count == presc);

    // Count up to presc and wrap; a presc write restarts the period from 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime, mtimecmp, msip and presc behind a 32-bit
// valid/ready register bus, driving the core's mtip and msip inputs.
module clint_timer
    import clint_pkg::*;
#(
    parameter int                 ADDR_W      = 5,
    parameter int                 PRESC_W     = 8,
    parameter logic [PRESC_W-1:0] PRESC_RESET = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_bus_valid,
    output logic              io_bus_ready,
    input  logic              io_bus_write,
    input  logic [ADDR_W-1:0] io_bus_addr,
    input  logic [31:0]       io_bus_wdata,
    output logic              io_bus_rvalid,
    output logic [31:0]       io_bus_rdata,
    output logic              io_interrupts_mtip,
    output logic              io_interrupts_msip
);

    bus_state_e         state;
    bus_state_e         state_next;
    logic               ready_c;
    logic               rvalid_c;
    logic               accept;
    logic               wr;
    logic [ADDR_W-1:0]  word_addr;
    logic               sel_msip, sel_cmp_lo, sel_cmp_hi;
    logic               sel_mt_lo, sel_mt_hi, sel_presc;
    logic               msip_q;
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               lo_carry;
    logic               mtip_q;
    logic [31:0]        rdata_c;
    logic [31:0]        rdata_q;

    // Byte lanes [1:0] are ignored: decode on the word-aligned address.
    assign word_addr  = io_bus_addr & ~ADDR_W'(3);
    assign sel_msip   = (word_addr == ADDR_W'(MSIP_OFF));
    assign sel_cmp_lo = (word_addr == ADDR_W'(MTIMECMP_LO_OFF));
    assign sel_cmp_hi = (word_addr == ADDR_W'(MTIMECMP_HI_OFF));
    assign sel_mt_lo  = (word_addr == ADDR_W'(MTIME_LO_OFF));
    assign sel_mt_hi  = (word_addr == ADDR_W'(MTIME_HI_OFF));
    assign sel_presc  = (word_addr == ADDR_W'(PRESC_OFF));

    // Bus FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus FSM next state and handshake outputs.
    always_comb begin
        state_next = state;
        ready_c    = 1'b0;
        rvalid_c   = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (io_bus_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rvalid_c   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign accept        = ready_c & io_bus_valid;
    assign wr            = accept & io_bus_write;
    // ready must read 0 while reset is held even though the FSM sits in IDLE.
    assign io_bus_ready  = ready_c & reset;
    assign io_bus_rvalid = rvalid_c;
    assign io_bus_rdata  = rdata_q;

    clint_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (wr & sel_presc),
        .presc (presc),
        .tick  (tick)
    );

    // Carry into the high half is taken from the pre-write low half.
    assign lo_carry = tick & (mtime[31:0] == 32'hFFFF_FFFF);

    // mtime: bus write to a half wins over that half's increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime <= '0;
        end else begin
            if (wr && sel_mt_lo) begin
                mtime[31:0] <= io_bus_wdata;
            end else if (tick) begin
                mtime[31:0] <= mtime[31:0] + 32'd1;
            end
            if (wr && sel_mt_hi) begin
                mtime[63:32] <= io_bus_wdata;
            end else if (lo_carry) begin
                mtime[63:32] <= mtime[63:32] + 32'd1;
            end
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtimecmp <= MTIMECMP_RESET;
            msip_q   <= 1'b0;
            presc    <= PRESC_RESET;
        end else if (wr) begin
            if (sel_cmp_lo) mtimecmp[31:0]  <= io_bus_wdata;
            if (sel_cmp_hi) mtimecmp[63:32] <= io_bus_wdata;
            if (sel_msip)   msip_q          <= io_bus_wdata[0];
            if (sel_presc)  presc           <= io_bus_wdata[PRESC_W-1:0];
        end
    end

    // Timer interrupt: registered unsigned 64-bit compare.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtip_q <= 1'b0;
        end else begin
            mtip_q <= (mtime >= mtimecmp);
        end
    end

    assign io_interrupts_mtip = mtip_q;
    assign io_interrupts_msip = msip_q;

    // Read mux; unmapped words read as zero.
    always_comb begin
        rdata_c = '0;
        if (sel_msip)        rdata_c = {31'b0, msip_q};
        else if (sel_cmp_lo) rdata_c = mtimecmp[31:0];
        else if (sel_cmp_hi) rdata_c = mtimecmp[63:32];
        else if (sel_mt_lo)  rdata_c = mtime[31:0];
        else if (sel_mt_hi)  rdata_c = mtime[63:32];
        else if (sel_presc)  rdata_c = 32'(presc);
    end

    // Response data captured at acceptance and held through RESP; writes return 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= io_bus_write ? 32'd0 : rdata_c;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: vector table, directed corner
// sequences and randomized traffic against a cycle-count timer model.
module tb_clint_timer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_bus_valid = 1'b0;
    logic        io_bus_write = 1'b0;
    logic [4:0]  io_bus_addr = '0;
    logic [31:0] io_bus_wdata = '0;
    logic        io_bus_ready;
    logic        io_bus_rvalid;
    logic [31:0] io_bus_rdata;
    logic        io_interrupts_mtip;
    logic        io_interrupts_msip;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    clint_timer dut (
        .clock              (clock),
        .reset              (reset),
        .io_bus_valid       (io_bus_valid),
        .io_bus_ready       (io_bus_ready),
        .io_bus_write       (io_bus_write),
        .io_bus_addr        (io_bus_addr),
        .io_bus_wdata       (io_bus_wdata),
        .io_bus_rvalid      (io_bus_rvalid),
        .io_bus_rdata       (io_bus_rdata),
        .io_interrupts_mtip (io_interrupts_mtip),
        .io_interrupts_msip (io_interrupts_msip)
    );

    // Reference model: mtime is the value m_base at edge m_edge plus the
    // number of prescaler periods (length m_p+1, phase m_pedge) elapsed since.
    logic [63:0] m_base;
    int          m_edge;
    int          m_pedge;
    int          m_p;
    logic [63:0] m_cmp;
    logic        m_msip;

    function automatic logic [63:0] m_after(int e);
        int per;
        per = m_p + 1;
        return m_base + 64'((e - m_pedge) / per - (m_edge - m_pedge) / per);
    endfunction

    task automatic model_init();
        m_base  = '0;
        m_edge  = cyc;
        m_pedge = cyc;
        m_p     = 0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip  = 1'b0;
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input int e);
        logic [63:0] v;
        case (a)
            5'h00: m_msip = d[0];
            5'h08: m_cmp[31:0] = d;
            5'h0C: m_cmp[63:32] = d;
            5'h10: begin v = m_after(e); v[31:0] = d;  m_base = v; m_edge = e; end
            5'h14: begin v = m_after(e); v[63:32] = d; m_base = v; m_edge = e; end
            5'h18: begin
                v = m_after(e); m_base = v; m_edge = e; m_pedge = e; m_p = int'(d[7:0]);
            end
            default: ;
        endcase
    endtask

    // Data returned by a read accepted at edge r (state just before that edge).
    function automatic logic [31:0] model_read(input logic [4:0] a, input int r);
        logic [63:0] v;
        v = m_after(r - 1);
        case (a)
            5'h00:   return {31'b0, m_msip};
            5'h08:   return m_cmp[31:0];
            5'h0C:   return m_cmp[63:32];
            5'h10:   return v[31:0];
            5'h14:   return v[63:32];
            5'h18:   return 32'(m_p);
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_irq(input string tag);
        chk({tag, "_mtip"}, io_interrupts_mtip, m_after(cyc - 1) >= m_cmp);
        chk({tag, "_msip"}, io_interrupts_msip, m_msip);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One bus transfer; starts and ends 1ns after a clock edge in IDLE.
    task automatic xfer(input logic wr, input logic [4:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int acc);
        int n;
        n = 0;
        io_bus_valid = 1'b1;
        io_bus_write = wr;
        io_bus_addr  = a;
        io_bus_wdata = d;
        while (io_bus_ready !== 1'b1 && n < 8) begin
            @(posedge clock); #1; n++;
        end
        if (io_bus_ready !== 1'b1) begin
            chk("ready_timeout", io_bus_ready, 1);
            io_bus_valid = 1'b0;
            rd  = '0;
            acc = cyc;
            return;
        end
        @(posedge clock); #1;
        acc = cyc;
        io_bus_valid = 1'b0;
        if (wr) model_write(a, d, acc);
        chk("resp_rvalid", io_bus_rvalid, 1);
        chk("resp_ready", io_bus_ready, 0);
        rd = io_bus_rdata;
        if (wr) chk("write_rdata", rd, 0);
        @(posedge clock); #1;
        chk("rvalid_pulse_end", io_bus_rvalid, 0);
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_msip;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [31:0] rd, rd1, rd2;
        int acc, acc1, acc2, w_mt, p_edge, rise, pulses;

        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd1, rd2;
        int acc, acc1, acc2, w_mt, p_edge, rise, pulses;

        tbl[0]  = '{1'b1, 5'h00, 32'h0000_0001, 32'h0, 1'b1};
        tbl[1]  = '{1'b1, 5'h00, 32'h0000_0000, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[3]  = '{1'b0, 5'h00, 32'h0,         32'h0000_0001, 1'b1};
        tbl[4]  = '{1'b1, 5'h04, 32'hDEAD_BEEF, 32'h0, 1'b1};
        tbl[5]  = '{1'b0, 5'h04, 32'h0,         32'h0, 1'b1};
        tbl[6]  = '{1'b0, 5'h1C, 32'h0,         32'h0, 1'b1};
        tbl[7]  = '{1'b1, 5'h0C, 32'h1234_5678, 32'h0, 1'b1};
        tbl[8]  = '{1'b0, 5'h0E, 32'h0,         32'h1234_5678, 1'b1};
        tbl[9]  = '{1'b1, 5'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1};
        tbl[10] = '{1'b0, 5'h08, 32'h0,         32'hFFFF_FFFF, 1'b1};
        tbl[11] = '{1'b1, 5'h18, 32'h0000_01AB, 32'h0, 1'b1};
        tbl[12] = '{1'b0, 5'h18, 32'h0,         32'h0000_00AB, 1'b1};
        tbl[13] = '{1'b1, 5'h18, 32'h0,         32'h0, 1'b1};
        tbl[14] = '{1'b0, 5'h1B, 32'h0,         32'h0, 1'b1};
        tbl[15] = '{1'b1, 5'h00, 32'h0,         32'h0, 1'b0};

        // Reset held for 10 cycles
        idle(10);
        chk("rst_ready", io_bus_ready, 0);
        chk("rst_rvalid", io_bus_rvalid, 0);
        chk("rst_rdata", io_bus_rdata, 0);
        chk("rst_mtip", io_interrupts_mtip, 0);
        chk("rst_msip", io_interrupts_msip, 0);
        reset = 1'b1;
        model_init();
        xfer(1'b0, 5'h0C, 32'h0, rd, acc);
        chk("rst_cmp_hi", rd, 32'hFFFF_FFFF);
        xfer(1'b0, 5'h10, 32'h0, rd, acc);
        chk("rst_mtime_lo", rd, model_read(5'h10, acc));
        chk("rst_mtime_small", rd < 32'd16, 1);
        chk_irq("rst");

        // Register vectors
        for (int i = 0; i < 16; i++) begin
            xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, acc);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_msip", i), io_interrupts_msip, tbl[i].exp_msip);
            chk_irq($sformatf("vec%0d", i));
        end

        // Timer fire with presc=0
        xfer(1'b1, 5'h10, 32'd0, rd, w_mt);
        xfer(1'b1, 5'h0C, 32'd0, rd, acc);
        xfer(1'b1, 5'h08, 32'd20, rd, acc);
        rise = -1;
        for (int i = 0; i < 30; i++) begin
            chk("fire_mtip", io_interrupts_mtip, m_after(cyc - 1) >= m_cmp);
            if (io_interrupts_mtip === 1'b1 && rise < 0) rise = cyc;
            @(posedge clock); #1;
        end
        chk("fire_rise_edge", rise, w_mt + 21);
        xfer(1'b1, 5'h08, 32'hFFFF_FFF0, rd, acc);
        chk("fire_fall", io_interrupts_mtip, 0);

        // Prescaler: presc=3 gives +10 over 40 clocks
        xfer(1'b1, 5'h18, 32'd3, rd, acc);
        idle(3);
        xfer(1'b0, 5'h10, 32'h0, rd1, acc1);
        chk("presc_rd1", rd1, model_read(5'h10, acc1));
        idle(38);
        xfer(1'b0, 5'h10, 32'h0, rd2, acc2);
        chk("presc_rd2", rd2, model_read(5'h10, acc2));
        chk("presc_span", acc2 - acc1, 40);
        chk("presc_delta", rd2 - rd1, 10);

        // Wrap and carry with presc=0, mtimecmp=0
        xfer(1'b1, 5'h18, 32'd0, rd, acc);
        xfer(1'b1, 5'h08, 32'd0, rd, acc);
        chk_irq("cmp0");
        chk("cmp0_mtip", io_interrupts_mtip, 1);
        xfer(1'b1, 5'h14, 32'hFFFF_FFFF, rd, acc);
        xfer(1'b1, 5'h10, 32'hFFFF_FFFE, rd, acc);
        xfer(1'b0, 5'h14, 32'h0, rd, acc);
        chk("wrap_hi_before", rd, 32'hFFFF_FFFF);
        xfer(1'b0, 5'h14, 32'h0, rd, acc);
        chk("wrap_hi_after", rd, 32'h0);
        xfer(1'b0, 5'h10, 32'h0, rd, acc);
        chk("wrap_lo_after", rd, 32'd3);
        chk("wrap_lo_model", rd, model_read(5'h10, acc));
        chk("wrap_mtip", io_interrupts_mtip, 1);

        // Write mtime_lo on the exact tick edge (presc=7)
        xfer(1'b1, 5'h18, 32'd7, rd, p_edge);
        idle(6);
        xfer(1'b1, 5'h10, 32'h0000_1000, rd, acc);
        chk("tickwr_edge", acc, p_edge + 8);
        xfer(1'b0, 5'h10, 32'h0, rd, acc);
        chk("tickwr_lo", rd, 32'h0000_1000);
        chk("tickwr_model", rd, model_read(5'h10, acc));

        // Back-to-back requests: ready 1,0,1,0.. and one rvalid per request
        pulses = 0;
        io_bus_valid = 1'b1;
        io_bus_write = 1'b0;
        io_bus_addr  = 5'h00;
        for (int i = 0; i < 6; i++) begin
            chk("b2b_ready", io_bus_ready, (i % 2) == 0);
            chk("b2b_rvalid", io_bus_rvalid, (i % 2) == 1);
            if (io_bus_rvalid === 1'b1) begin
                pulses++;
                chk("b2b_rdata", io_bus_rdata, {31'b0, m_msip});
            end
            if (i == 5) io_bus_valid = 1'b0;
            @(posedge clock); #1;
        end
        chk("b2b_pulses", pulses, 3);

        // A request raised during RESP and dropped before IDLE is lost
        io_bus_valid = 1'b1;
        io_bus_write = 1'b0;
        io_bus_addr  = 5'h00;
        @(posedge clock); #1;
        io_bus_write = 1'b1;
        io_bus_wdata = 32'h1;
        @(posedge clock); #1;
        io_bus_valid = 1'b0;
        idle(2);
        chk("drop_msip", io_interrupts_msip, 0);
        xfer(1'b0, 5'h00, 32'h0, rd, acc);
        chk("drop_rd_msip", rd, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            logic        w;
            logic [4:0]  a;
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 7) << 2);
            d = (a == 5'h18) ? 32'($urandom_range(0, 5)) : $urandom;
            xfer(w, a, d, rd, acc);
            if (!w) chk($sformatf("rand_rd_%0h", a), rd, model_read(a, acc));
            chk_irq("rand");
            idle($urandom_range(0, 3));
        end

        // Reset asserted while in RESP
        xfer(1'b1, 5'h00, 32'h1, rd, acc);
        xfer(1'b1, 5'h08, 32'h0, rd, acc);
        xfer(1'b1, 5'h0C, 32'h0, rd, acc);
        idle(1);
        chk("pre_rst_mtip", io_interrupts_mtip, 1);
        io_bus_valid = 1'b1;
        io_bus_write = 1'b0;
        io_bus_addr  = 5'h00;
        @(posedge clock); #1;
        io_bus_valid = 1'b0;
        chk("midrst_rvalid_before", io_bus_rvalid, 1);
        chk("midrst_rdata_before", io_bus_rdata, 1);
        reset = 1'b0;
        #1;
        chk("midrst_rvalid", io_bus_rvalid, 0);
        chk("midrst_ready", io_bus_ready, 0);
        chk("midrst_rdata", io_bus_rdata, 0);
        chk("midrst_mtip", io_interrupts_mtip, 0);
        chk("midrst_msip", io_interrupts_msip, 0);
        idle(3);
        reset = 1'b1;
        model_init();
        xfer(1'b0, 5'h0C, 32'h0, rd, acc);
        chk("postrst_cmp_hi", rd, 32'hFFFF_FFFF);
        xfer(1'b0, 5'h18, 32'h0, rd, acc);
        chk("postrst_presc", rd, 0);
        xfer(1'b0, 5'h14, 32'h0, rd, acc);
        chk("postrst_mtime_hi", rd, 0);
        chk_irq("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
